// File: rtl/sram_2p_ctrl_pkg.sv
// Shared constants and FSM state type for the two-port SRAM controller.
// No logic; no latency; no backpressure.
package sram_2p_ctrl_pkg;
  localparam int BITS_DEF  = 233;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with one-hot grants.
// Grant is combinational, 0 cycles. Losers hold their request until granted.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr_q;

  // The pointer only matters under contention, so it advances only then.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n)                   ptr_q <= 1'b0;
    else if (en && req == 2'b11)    ptr_q <= ~ptr_q;
  end
endmodule

// File: rtl/sram_2p_ctrl.sv
// Two-port SRAM controller: zero-fill on reset, one writer, two arbitrated readers.
// Reads return 1 cycle after grant. Writes never stall in RUN; responses cannot be backpressured.
module sram_2p_ctrl
  import sram_2p_ctrl_pkg::*;
#(
  parameter int BITS  = BITS_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [BITS-1:0] wr_data,
  input  logic            rd0_valid,
  output logic            rd0_ready,
  input  logic [AW-1:0]   rd0_addr,
  input  logic            rd1_valid,
  output logic            rd1_ready,
  input  logic [AW-1:0]   rd1_addr,
  output logic            resp0_valid,
  output logic [BITS-1:0] resp0_data,
  output logic            resp1_valid,
  output logic [BITS-1:0] resp1_data,
  output logic            sram_WEB,
  output logic [AW-1:0]   sram_AA,
  output logic [BITS-1:0] sram_D,
  output logic            sram_REB,
  output logic [AW-1:0]   sram_AB,
  input  logic [BITS-1:0] sram_Q,
  output logic            init_done
);
  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            run;
  logic [1:0]      gnt;
  logic            hit;
  logic            rv0_q, rv1_q, byp_q;
  logic [BITS-1:0] byp_data_q;
  logic [BITS-1:0] rd_data;

  // Everything is gated by reset_n so the macro sees no access in a reset cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    run       = 1'b0;
    init_done = 1'b0;
    wr_ready  = 1'b0;
    sram_WEB  = 1'b1;
    sram_AA   = '0;
    sram_D    = '0;
    if (reset_n) begin
      case (state_q)
        INIT: begin
          sram_WEB = 1'b0;
          sram_AA  = cnt_q;
          if (cnt_q == AW'(DEPTH - 1)) state_d = RUN;
          else                         cnt_d   = cnt_q + AW'(1);
        end
        RUN: begin
          run       = 1'b1;
          init_done = 1'b1;
          wr_ready  = 1'b1;
          if (wr_valid) begin
            sram_WEB = 1'b0;
            sram_AA  = wr_addr;
            sram_D   = wr_data;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  rr_arb2 u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (run),
    .req     ({rd1_valid, rd0_valid}),
    .gnt     (gnt)
  );

  assign rd0_ready = gnt[0];
  assign rd1_ready = gnt[1];
  assign sram_REB  = ~|gnt;
  assign sram_AB   = gnt[1] ? rd1_addr : (gnt[0] ? rd0_addr : '0);

  // The macro returns old data on a same-address collision, so capture the write.
  assign hit = (|gnt) && !sram_WEB && (sram_AA == sram_AB);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      byp_q <= 1'b0;
    end else begin
      rv0_q <= gnt[0];
      rv1_q <= gnt[1];
      byp_q <= hit;
    end
  end

  always_ff @(posedge clock) begin
    if (hit) byp_data_q <= wr_data;
  end

  assign rd_data     = byp_q ? byp_data_q : sram_Q;
  assign resp0_valid = rv0_q && reset_n;
  assign resp1_valid = rv1_q && reset_n;
  assign resp0_data  = resp0_valid ? rd_data : '0;
  assign resp1_data  = resp1_valid ? rd_data : '0;
endmodule

// File: tb/tb_sram_2p_ctrl.sv
// Randomized and directed bench for sram_2p_ctrl with a behavioural SRAM macro and reference model.
module tb_sram_2p_ctrl;
  localparam int BITS  = 233;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            wr_valid = 1'b0, wr_ready;
  logic [AW-1:0]   wr_addr = '0;
  logic [BITS-1:0] wr_data = '0;
  logic            rd0_valid = 1'b0, rd0_ready;
  logic [AW-1:0]   rd0_addr = '0;
  logic            rd1_valid = 1'b0, rd1_ready;
  logic [AW-1:0]   rd1_addr = '0;
  logic            resp0_valid, resp1_valid;
  logic [BITS-1:0] resp0_data, resp1_data;
  logic            sram_WEB, sram_REB;
  logic [AW-1:0]   sram_AA, sram_AB;
  logic [BITS-1:0] sram_D;
  logic [BITS-1:0] sram_Q = '0;
  logic            init_done;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;

  sram_2p_ctrl #(.BITS(BITS), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .sram_WEB(sram_WEB), .sram_AA(sram_AA), .sram_D(sram_D),
    .sram_REB(sram_REB), .sram_AB(sram_AB), .sram_Q(sram_Q),
    .init_done(init_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Macro model: read-before-write on a same-address collision, Q holds between reads.
  logic [BITS-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = {BITS{1'b1}} ^ BITS'(i);
  always @(posedge clock) begin
    if (!sram_REB) sram_Q <= mem[sram_AB];
    if (!sram_WEB) mem[sram_AA] <= sram_D;
  end

  task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @cyc%0d act=%h exp=%h", name, cyc, act, exp);
  endtask

  function automatic logic [BITS-1:0] rand_data();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[BITS-1:0];
  endfunction

  // Reference model state: contents, init progress, contention pointer, one pending response.
  logic [BITS-1:0] exp_mem [DEPTH];
  bit  m_init = 1'b1;
  int  m_cnt = 0;
  bit  m_ptr = 1'b0;
  bit  m_p0 = 1'b0, m_p1 = 1'b0;
  logic [BITS-1:0] m_pd = '0;

  always @(negedge clock) begin
    bit g0, g1;
    logic [AW-1:0] a;
    #1;
    if (!reset_n) begin
      chk("rst_web", sram_WEB, 1);
      chk("rst_reb", sram_REB, 1);
      chk("rst_rdy", {wr_ready, rd0_ready, rd1_ready, init_done}, 0);
      chk("rst_rv", {resp0_valid, resp1_valid}, 0);
      chk("rst_rd0", resp0_data, 0);
      chk("rst_rd1", resp1_data, 0);
      m_init = 1'b1; m_cnt = 0; m_ptr = 1'b0; m_p0 = 1'b0; m_p1 = 1'b0;
    end else begin
      chk("resp0_valid", resp0_valid, m_p0);
      chk("resp0_data", resp0_data, m_p0 ? m_pd : '0);
      chk("resp1_valid", resp1_valid, m_p1);
      chk("resp1_data", resp1_data, m_p1 ? m_pd : '0);
      g0 = 1'b0; g1 = 1'b0;
      if (m_init) begin
        chk("init_web", sram_WEB, 0);
        chk("init_aa", sram_AA, m_cnt);
        chk("init_d", sram_D, 0);
        chk("init_reb", sram_REB, 1);
        chk("init_rdy", {wr_ready, rd0_ready, rd1_ready, init_done}, 0);
        exp_mem[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) m_init = 1'b0;
        else m_cnt++;
      end else begin
        if (rd0_valid && rd1_valid) begin
          if (m_ptr) g1 = 1'b1; else g0 = 1'b1;
          m_ptr = ~m_ptr;
        end else begin
          g0 = rd0_valid; g1 = rd1_valid;
        end
        chk("run_flags", {wr_ready, init_done}, 2'b11);
        chk("run_web", sram_WEB, !wr_valid);
        if (wr_valid) begin
          chk("run_aa", sram_AA, wr_addr);
          chk("run_d", sram_D, wr_data);
        end
        chk("grant", {rd1_ready, rd0_ready}, {g1, g0});
        chk("run_reb", sram_REB, !(g0 || g1));
        if (g0 || g1) begin
          a = g0 ? rd0_addr : rd1_addr;
          chk("run_ab", sram_AB, a);
          m_pd = (wr_valid && wr_addr == a) ? wr_data : exp_mem[a];
        end
        if (wr_valid) exp_mem[wr_addr] = wr_data;
      end
      m_p0 = g0; m_p1 = g1;
    end
  end

  task automatic drive(input bit rn, input bit wv, input int wa, input logic [BITS-1:0] wd,
                       input bit r0v, input int r0a, input bit r1v, input int r1a);
    @(negedge clock);
    reset_n = rn; wr_valid = wv; wr_addr = AW'(wa); wr_data = wd;
    rd0_valid = r0v; rd0_addr = AW'(r0a); rd1_valid = r1v; rd1_addr = AW'(r1a);
  endtask

  task automatic idle();
    drive(1, 0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, 0, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0);
    // Zero fill: addresses 0..15 on consecutive cycles, then RUN.
    for (int i = 0; i < DEPTH; i++) begin
      idle(); #2;
      chk("L_init_aa", sram_AA, i);
      chk("L_init_done_lo", init_done, 0);
    end
    idle(); #2;
    chk("L_init_done_hi", init_done, 1);

    drive(1, 0, 0, '0, 1, 5, 0, 0); #2;
    chk("L_rd5_rdy", rd0_ready, 1);
    idle(); #2;
    chk("L_rd5_resp", {resp0_valid, resp0_data}, {1'b1, {BITS{1'b0}}});

    drive(1, 1, 3, BITS'(32'h1ABC), 0, 0, 0, 0);
    drive(1, 0, 0, '0, 1, 3, 0, 0);
    idle(); #2;
    chk("L_rd3_data", resp0_data, BITS'(32'h1ABC));
    chk("L_rd3_v", {resp0_valid, resp1_valid}, 2'b10);
    idle(); #2;
    chk("L_rd3_one_cycle", resp0_valid, 0);

    // Contention: grants alternate 0,1,0,1 and responses follow on their own port.
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, '0, 1, 1, 1, 2); #2;
      chk("L_rr_grant", {rd1_ready, rd0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("L_rr_resp", {resp1_valid, resp0_valid}, (k % 2 == 1) ? 2'b01 : 2'b10);
    end
    idle(); #2;
    chk("L_rr_last", {resp1_valid, resp0_valid}, 2'b10);

    drive(1, 1, 7, BITS'(32'h11), 0, 0, 0, 0);
    drive(1, 1, 7, BITS'(32'h55), 0, 0, 1, 7);
    idle(); #2;
    chk("L_bypass", resp1_data, BITS'(32'h55));

    drive(1, 1, 9, BITS'(32'h99), 0, 0, 0, 0);
    drive(1, 1, 2, BITS'(32'h22), 1, 9, 0, 0); #2;
    chk("L_dual_ports", {sram_WEB, sram_REB, sram_AA, sram_AB}, {2'b00, 4'd2, 4'd9});
    idle(); #2;
    chk("L_dual_data", resp0_data, BITS'(32'h99));

    // Reset in the response cycle drops the response and restarts zero fill.
    drive(1, 0, 0, '0, 1, 3, 0, 0);
    drive(0, 0, 0, '0, 0, 0, 0, 0); #2;
    chk("L_rst_drop", resp0_valid, 0);
    idle(); #2;
    chk("L_rst_restart", {sram_WEB, sram_AA}, {1'b0, 4'd0});
    for (int i = 1; i < DEPTH; i++) idle();

    for (int n = 0; n < 1500; n++) begin
      int wa, ra0, ra1;
      wa  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      ra0 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      ra1 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1, wa, rand_data(),
            $urandom_range(0, 2) != 0, ra0, $urandom_range(0, 2) != 0, ra1);
    end
    idle();
    idle(); #2;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
